midi_msg_parser: RTL and testbench
==================================

Name: midi_msg_parser

Overview:
- Byte-level MIDI message parser; sits directly downstream of the MIDI UART receiver.
- Consumes one received byte per strobe and tracks status and running status.
- Assembles channel voice messages and emits decoded note/controller events to the stepper voice allocator over a valid/ready handshake.
- Single Clk domain. The upstream byte strobe is already synchronised to Clk.

Parameters:
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL
- CHANNEL, 0, 4-bit MIDI channel (0..15) accepted when OMNI=0

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous, active-low reset
- byte_in  in  8  received MIDI byte; sampled only when byte_vld=1
- byte_vld  in  1  one-Clk strobe: byte_in is a new byte
- ev_valid  out  1  decoded event available
- ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
- ev_type  out  2  0=NOTE_OFF, 1=NOTE_ON, 2=CTRL_CHANGE, 3=PITCH_BEND
- ev_chan  out  4  event channel
- ev_d1  out  7  note number / controller number / bend LSB
- ev_d2  out  7  velocity / controller value / bend MSB
- overflow  out  1  sticky: an event was dropped
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (async) values:
  - ev_valid=0; ev_type/ev_chan/ev_d1/ev_d2=0; overflow=0.
  - Internal: running status=none, state=WAIT_STATUS.
- States: WAIT_STATUS, WAIT_D1, WAIT_D2, SKIP.
- A byte is processed only in a cycle with byte_vld=1. All other cycles hold state.
- Real-time bytes (0xF8..0xFF):
  - Ignored in every state.
  - State, running status and the partial d1 are unchanged.
- System common / SysEx (0xF0..0xF7):
  - Clear running status; go to SKIP.
  - In SKIP, data bytes (<0x80) are discarded until the next channel status byte.
- Channel status byte (0x80..0xEF):
  - Latch as running status; go to WAIT_D1. Any partial message is discarded silently.
- Data byte (<0x80):
  - WAIT_STATUS or SKIP with no running status: discard.
  - WAIT_STATUS with running status set: treat as d1.
  - WAIT_D1: latch d1.
    - Types 0x8n/0x9n/0xAn/0xBn/0xEn go to WAIT_D2.
    - Two-byte types 0xCn/0xDn are complete; no event; return to WAIT_STATUS.
  - WAIT_D2: latch d2; message complete; return to WAIT_STATUS (running status retained).
- Event generation on completion (only if channel passes the OMNI/CHANNEL filter):
  - 0x8n: NOTE_OFF, d2 = release velocity.
  - 0x9n with d2≠0: NOTE_ON.
  - 0x9n with d2=0: NOTE_OFF with ev_d2=0.
  - 0xBn: CTRL_CHANGE.
  - 0xAn (poly pressure): discarded.
  - 0xEn: see Optional Feature.
- Output register (1 entry):
  - The event appears on ev_* with ev_valid=1 in the Clk after the completing byte_vld cycle (latency 1).
  - ev_* are stable while ev_valid=1 & ev_ready=0.
  - On ev_valid & ev_ready, ev_valid drops next cycle unless a new event loads in the same cycle; back-to-back loading is allowed.
- Overflow:
  - Event completes while ev_valid=1 & ev_ready=0: the new event is dropped, the old one is kept, and overflow is set.
  - clr_ovf and a new overflow in the same cycle: set wins.
- Parser never stalls byte intake; byte_vld needs no back-pressure.

Optional Feature:
- Macro MIDI_PARSER_PITCHBEND_EN.
- Defined: 0xEn completes with an event ev_type=PITCH_BEND, ev_d1=LSB, ev_d2=MSB (consumer forms the 14-bit value {d2,d1}; centre 0x2000).
- Undefined: 0xEn is parsed for framing (both data bytes consumed) but no event is emitted; ev_type=3 never appears.

Decomposition:
- Shared package midi_pkg:
  - Event-type encodings NOTE_OFF/NOTE_ON/CTRL_CHANGE/PITCH_BEND.
  - Status high-nibble constants (0x8..0xF).
  - Parser state enum.
  - Real-time threshold 0xF8.
- One natural sub-module midi_evt_reg: 1-entry valid/ready output register with the overflow flag. The parser FSM stays in the top.

Test Plan:
- 0x90,0x3C,0x64 -> one cycle after the third strobe: ev_valid=1, NOTE_ON, chan 0, d1=0x3C, d2=0x64; held with ev_ready=0.
- Running status 0x91,0x40,0x50,0x40,0x00 -> NOTE_ON ch1 0x40/0x50, then NOTE_OFF ch1 0x40/0x00.
- 0x90,0x3C,0xF8,0x64 -> single NOTE_ON 0x3C/0x64; the clock byte does not disturb parsing.
- 0xF0,0x7E,0x01,0xF7,0x45 -> no events (running status cleared). Then 0xB2,0x07,0x7F -> CTRL_CHANGE ch2 0x07/0x7F.
- With ev_ready=0, send two complete NOTE_ONs -> first event held, overflow=1. Pulse clr_ovf -> overflow=0. Assert Rst_n=0 mid-message (after 0x90,0x3C) -> all outputs 0, and the following 0x64 is discarded.
- OMNI=0, CHANNEL=5: 0x94,0x30,0x10 -> no event; 0x95,0x30,0x10 -> NOTE_ON ch5. With the macro defined, 0xE0,0x00,0x40 -> PITCH_BEND 0x00/0x40; without it -> no event.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI parser types: event encodings, status nibbles, parser states.
// Imported by the parser top and its output register.
package midi_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF    = 2'd0,
        EV_NOTE_ON     = 2'd1,
        EV_CTRL_CHANGE = 2'd2,
        EV_PITCH_BEND  = 2'd3
    } ev_type_e;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2,
        SKIP        = 2'd3
    } parse_state_e;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;
    localparam logic [3:0] ST_SYSTEM   = 4'hF;

    localparam logic [7:0] RT_THRESHOLD = 8'hF8;

    typedef struct packed {
        ev_type_e   typ;
        logic [3:0] chan;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_ev_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic has_d2(input logic [3:0] hi);
        return (hi != ST_PROG) && (hi != ST_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_evt_reg.sv
// One-entry valid/ready event register with a sticky overflow flag.
module midi_evt_reg
    import midi_pkg::*;
(
    input  logic     Clk,
    input  logic     Rst_n,
    input  logic     ld,
    input  midi_ev_t ld_ev,
    input  logic     ev_ready,
    input  logic     clr_ovf,
    output logic     ev_valid,
    output midi_ev_t ev,
    output logic     overflow
);

    logic accept;

    assign accept = ~ev_valid | ev_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ev_valid <= 1'b0;
            ev       <= '0;
            overflow <= 1'b0;
        end else begin
            if (ld && accept) begin
                ev_valid <= 1'b1;
                ev       <= ld_ev;
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
            // A dropped event outranks a same-cycle clear.
            if (ld && !accept) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status, emitting note/CC events.
// Define MIDI_PARSER_PITCHBEND_EN to emit pitch-bend events.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_type,
    output logic [3:0] ev_chan,
    output logic [6:0] ev_d1,
    output logic [6:0] ev_d2,
    output logic       overflow,
    input  logic       clr_ovf
);

    parse_state_e state;
    logic [7:0]   run_st;
    logic         rs_vld;
    logic [6:0]   d1_q;

    logic is_rt;
    logic is_sys;
    logic is_stat;
    logic is_data;
    logic take_d1;
    logic take_d2;
    logic chan_ok;
    logic emit;
    logic ld;

    midi_ev_t new_ev;
    midi_ev_t ev_q;

    assign is_rt   = byte_in >= RT_THRESHOLD;
    assign is_sys  = (byte_in[7:4] == ST_SYSTEM) && !is_rt;
    assign is_stat = byte_in[7] && (byte_in[7:4] != ST_SYSTEM);
    assign is_data = !byte_in[7];

    // Data in WAIT_STATUS/SKIP only counts as d1 under running status.
    assign take_d1 = byte_vld && is_data && rs_vld && (state != WAIT_D2);
    assign take_d2 = byte_vld && is_data && (state == WAIT_D2);

    assign chan_ok = (OMNI != 0) || (run_st[3:0] == CHANNEL[3:0]);
    assign ld      = take_d2 && emit && chan_ok;

    always_comb begin
        new_ev.typ  = EV_NOTE_OFF;
        new_ev.chan = run_st[3:0];
        new_ev.d1   = d1_q;
        new_ev.d2   = byte_in[6:0];
        emit        = 1'b0;
        unique case (run_st[7:4])
            ST_NOTE_OFF: begin
                emit = 1'b1;
            end
            ST_NOTE_ON: begin
                emit = 1'b1;
                if (byte_in[6:0] != 7'd0) begin
                    new_ev.typ = EV_NOTE_ON;
                end
            end
            ST_CTRL: begin
                emit       = 1'b1;
                new_ev.typ = EV_CTRL_CHANGE;
            end
`ifdef MIDI_PARSER_PITCHBEND_EN
            ST_BEND: begin
                emit       = 1'b1;
                new_ev.typ = EV_PITCH_BEND;
            end
`endif
            default: begin
                emit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= WAIT_STATUS;
            run_st <= '0;
            rs_vld <= 1'b0;
            d1_q   <= '0;
        end else if (byte_vld) begin
            unique case (1'b1)
                is_rt: ;
                is_sys: begin
                    state  <= SKIP;
                    rs_vld <= 1'b0;
                end
                is_stat: begin
                    run_st <= byte_in;
                    rs_vld <= 1'b1;
                    state  <= WAIT_D1;
                end
                default: begin
                    if (take_d2) begin
                        state <= WAIT_STATUS;
                    end else if (take_d1) begin
                        d1_q  <= byte_in[6:0];
                        state <= has_d2(run_st[7:4]) ?
                                 WAIT_D2 : WAIT_STATUS;
                    end
                end
            endcase
        end
    end

    midi_evt_reg u_evt_reg (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ld       (ld),
        .ld_ev    (new_ev),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev       (ev_q),
        .overflow (overflow)
    );

    assign ev_type = ev_q.typ;
    assign ev_chan = ev_q.chan;
    assign ev_d1   = ev_q.d1;
    assign ev_d2   = ev_q.d2;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench: an omni parser and a channel-5 parser share one byte stream.
`timescale 1ns/1ps
module tb_midi_msg_parser;

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } tev_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_vld = 1'b0;
    logic       ev_ready = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       v0, v1, o0, o1;
    logic [1:0] t0, t1;
    logic [3:0] c0, c1;
    logic [6:0] a0, a1, b0, b1;

    int n_tests = 0;
    int n_fail  = 0;

    tev_t q0[$];
    tev_t q1[$];
    bit   m_held[2];
    bit   m_held_n[2];
    bit   m_ovf[2];
    bit   m_ovf_n[2];
    int   m_rs = -1;
    logic [6:0] m_data[$];
    bit   mon_en = 1'b0;
    bit   rdy = 1'b0;

    always #5 Clk = ~Clk;

    midi_msg_parser #(.OMNI(1), .CHANNEL(0)) u_omni (
        .Clk(Clk), .Rst_n(Rst_n), .byte_in(byte_in), .byte_vld(byte_vld),
        .ev_valid(v0), .ev_ready(ev_ready), .ev_type(t0), .ev_chan(c0),
        .ev_d1(a0), .ev_d2(b0), .overflow(o0), .clr_ovf(clr_ovf)
    );

    midi_msg_parser #(.OMNI(0), .CHANNEL(5)) u_ch5 (
        .Clk(Clk), .Rst_n(Rst_n), .byte_in(byte_in), .byte_vld(byte_vld),
        .ev_valid(v1), .ev_ready(ev_ready), .ev_type(t1), .ev_chan(c1),
        .ev_d1(a1), .ev_d2(b1), .overflow(o1), .clr_ovf(clr_ovf)
    );

    // Message-level reference: collect data bytes behind the last status.
    task automatic model_byte(input logic [7:0] b, output bit comp, output tev_t e);
        logic [3:0] hi;
        int need;
        comp = 1'b0;
        e = '0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_rs = -1;
            m_data.delete();
            return;
        end
        if (b >= 8'h80) begin
            m_rs = int'(b);
            m_data.delete();
            return;
        end
        if (m_rs < 0) return;
        m_data.push_back(b[6:0]);
        hi = 4'(m_rs / 16);
        need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
        if (m_data.size() < need) return;
        e.c  = 4'(m_rs % 16);
        e.d1 = m_data[0];
        e.d2 = (need == 2) ? m_data[1] : 7'd0;
        m_data.delete();
        case (hi)
            4'h8: begin comp = 1'b1; e.t = 2'd0; end
            4'h9: begin comp = 1'b1; e.t = (e.d2 != 0) ? 2'd1 : 2'd0; end
            4'hB: begin comp = 1'b1; e.t = 2'd2; end
`ifdef MIDI_PARSER_PITCHBEND_EN
            4'hE: begin comp = 1'b1; e.t = 2'd3; end
`endif
            default: comp = 1'b0;
        endcase
    endtask

    task automatic model_reset();
        m_rs = -1;
        m_data.delete();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_held[k] = 0; m_held_n[k] = 0;
            m_ovf[k] = 0;  m_ovf_n[k] = 0;
        end
    endtask

    task automatic cycle(input bit vld, input logic [7:0] b, input bit r, input bit clr);
        bit comp, ld, acc;
        tev_t e;
        @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_held[k] = m_held_n[k];
            m_ovf[k]  = m_ovf_n[k];
        end
        byte_vld = vld; byte_in = b; ev_ready = r; clr_ovf = clr;
        comp = 1'b0;
        e = '0;
        if (vld) model_byte(b, comp, e);
        for (int k = 0; k < 2; k++) begin
            ld  = comp && (k == 0 || e.c == 4'd5);
            acc = !m_held[k] || r;
            if (ld && acc) begin
                if (k == 0) q0.push_back(e); else q1.push_back(e);
                m_held_n[k] = 1'b1;
            end else if (r) begin
                m_held_n[k] = 1'b0;
            end else begin
                m_held_n[k] = m_held[k];
            end
            if (ld && !acc) m_ovf_n[k] = 1'b1;
            else if (clr)   m_ovf_n[k] = 1'b0;
            else            m_ovf_n[k] = m_ovf[k];
        end
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, rdy, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom), rdy, 1'b0);
    endtask

    task automatic check_out(input int k, input logic v, input tev_t got, input logic ovf);
        tev_t exp;
        bit empty;
        n_tests++;
        if (v !== m_held[k]) begin
            n_fail++;
            $display("FAIL valid%0d got %0b want %0b at %0t", k, v, m_held[k], $time);
        end
        n_tests++;
        if (ovf !== m_ovf[k]) begin
            n_fail++;
            $display("FAIL overflow%0d got %0b want %0b at %0t", k, ovf, m_ovf[k], $time);
        end
        if (v === 1'b1) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            n_tests++;
            if (empty) begin
                n_fail++;
                $display("FAIL event%0d unexpected t=%0d c=%0d d1=%h d2=%h at %0t",
                         k, got.t, got.c, got.d1, got.d2, $time);
            end else begin
                exp = (k == 0) ? q0[0] : q1[0];
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL event%0d got t=%0d c=%0d d1=%h d2=%h want t=%0d c=%0d d1=%h d2=%h at %0t",
                             k, got.t, got.c, got.d1, got.d2, exp.t, exp.c, exp.d1, exp.d2, $time);
                end
                if (ev_ready) begin
                    if (k == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge Clk) begin
        if (mon_en && Rst_n) begin
            check_out(0, v0, tev_t'({t0, c0, a0, b0}), o0);
            check_out(1, v1, tev_t'({t1, c1, a1, b1}), o1);
        end
    end

    task automatic check_zero(input string name);
        n_tests++;
        if ({v0, t0, c0, a0, b0, o0, v1, t1, c1, a1, b1, o1} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs got %b want all 0", name,
                     {v0, t0, c0, a0, b0, o0, v1, t1, c1, a1, b1, o1});
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        byte_vld = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #2;
        check_zero("reset_mid");
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        model_reset();
        #12;
        check_zero("reset_init");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        mon_en = 1'b1;

        rdy = 1'b0;
        send(8'h90); send(8'h3C); send(8'h64);
        idle(4);
        rdy = 1'b1;
        idle(2);

        send(8'h91); send(8'h40); send(8'h50); send(8'h40); send(8'h00);
        idle(2);

        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        idle(2);

        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h45);
        idle(2);
        send(8'hB2); send(8'h07); send(8'h7F);
        idle(2);

        rdy = 1'b0;
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3D); send(8'h64);
        idle(2);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);
        rdy = 1'b1;
        idle(2);
        rdy = 1'b0;
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        idle(3);

        rdy = 1'b1;
        send(8'h94); send(8'h30); send(8'h10);
        send(8'h95); send(8'h30); send(8'h10);
        send(8'hE0); send(8'h00); send(8'h40);
        send(8'hE5); send(8'h7F); send(8'h7F);
        send(8'hC5); send(8'h11); send(8'h12);
        idle(3);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                b = {1'b1, 3'($urandom_range(0, 6)),
                     ($urandom_range(0, 2) == 0) ? 4'd5 : 4'($urandom_range(0, 15))};
            end else if (r < 15) begin
                b = 8'hF0 + 8'($urandom_range(0, 7));
            end else if (r < 20) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
            end else if (r < 26) begin
                b = 8'h00;
            end else begin
                b = {1'b0, 7'($urandom)};
            end
            cycle(($urandom_range(0, 3) != 0), b,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        rdy = 1'b1;
        idle(5);
        mon_en = 1'b0;
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
